// File: rtl/unidade_controle.sv
// unidade_controle: multi-cycle control FSM for the 8-bit ALU datapath.
//   Fetches an instruction byte into IR, decodes it and steps the datapath through
//   BUSCA -> DECODIFICA -> EXECUTA -> MEMORIA -> ESCRITA. HALT parks the FSM in PARADO.
//   ISA: IR[7:5]=op, IR[4:3]=ra, IR[2:1]=rb, IR[0]=halt bit (only meaningful for op 111).
// Ports:
//   clock, reset_n        clock (rising edge), asynchronous active-low reset
//   mem_dado[7:0]         instruction byte, captured in BUSCA when mem_pronto=1
//   mem_pronto            memory access completes in the cycle it is high
//   zero                  ALU zero flag, used by BEQ in EXECUTA
//   sinal_ula[2:0]        ALU operation
//   reg_a, reg_b          register selects (IR[4:3], IR[2:1])
//   mem_le, mem_escreve   memory read / write request (held through the wait)
//   sel_endereco          memory address source: 0=PC, 1=rb
//   pc_escreve, pc_fonte  PC load strobe, PC source (0=PC+1, 1=PC+2)
//   reg_escreve           register file write strobe
//   sel_mem_reg           writeback source: 0=ALU, 1=memory
//   parado                high in PARADO
//   erro_timeout          sticky memory timeout flag
// Build option: define CONTROLE_TIMEOUT_EN to enable the memory wait timeout.
module unidade_controle #(
  parameter int TIMEOUT_CICLOS = 15,
  parameter int LARGURA_CONT   = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] mem_dado,
  input  logic       mem_pronto,
  input  logic       zero,
  output logic [2:0] sinal_ula,
  output logic [1:0] reg_a,
  output logic [1:0] reg_b,
  output logic       mem_le,
  output logic       mem_escreve,
  output logic       sel_endereco,
  output logic       pc_escreve,
  output logic       pc_fonte,
  output logic       reg_escreve,
  output logic       sel_mem_reg,
  output logic       parado,
  output logic       erro_timeout
);

  typedef enum logic [2:0] {
    BUSCA      = 3'd0,
    DECODIFICA = 3'd1,
    EXECUTA    = 3'd2,
    MEMORIA    = 3'd3,
    ESCRITA    = 3'd4,
    PARADO     = 3'd5
  } estado_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_LW  = 3'b101;
  localparam logic [2:0] OP_SW  = 3'b110;
  localparam logic [2:0] OP_BEQ = 3'b111;

  // The wait counter must be able to represent the timeout limit.
  if (TIMEOUT_CICLOS < 1 || TIMEOUT_CICLOS >= (1 << LARGURA_CONT)) begin : g_cfg_err
    $error("unidade_controle: LARGURA_CONT too small for TIMEOUT_CICLOS");
  end

  estado_t    estado_q, estado_d;
  logic [7:0] ir_q, ir_d;
  logic [2:0] op;
  logic       limite;   // wait limit hit this cycle with no handshake

  assign op = ir_q[7:5];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= BUSCA;
      ir_q     <= 8'h00;
    end else begin
      estado_q <= estado_d;
      ir_q     <= ir_d;
    end
  end

`ifdef CONTROLE_TIMEOUT_EN
  logic [LARGURA_CONT-1:0] cont_q, cont_d;
  logic                    espera;
  logic                    erro_q, erro_d;

  assign espera = ((estado_q == BUSCA) || (estado_q == MEMORIA)) && !mem_pronto;
  // Handshake wins: limite only fires while mem_pronto is still low.
  assign limite = espera && (cont_q == LARGURA_CONT'(TIMEOUT_CICLOS - 1));
  // Counter runs only while parked in a wait state; any state change clears it.
  assign cont_d = (espera && !limite) ? cont_q + 1'b1 : '0;
  assign erro_d = erro_q | limite;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cont_q <= '0;
      erro_q <= 1'b0;
    end else begin
      cont_q <= cont_d;
      erro_q <= erro_d;
    end
  end

  assign erro_timeout = erro_q;
`else
  assign limite       = 1'b0;
  assign erro_timeout = 1'b0;
`endif

  assign reg_a  = ir_q[4:3];
  assign reg_b  = ir_q[2:1];
  assign parado = (estado_q == PARADO);

  always_comb begin
    estado_d     = estado_q;
    ir_d         = ir_q;
    sinal_ula    = OP_AND;
    mem_le       = 1'b0;
    mem_escreve  = 1'b0;
    sel_endereco = 1'b0;
    pc_escreve   = 1'b0;
    pc_fonte     = 1'b0;
    reg_escreve  = 1'b0;
    sel_mem_reg  = 1'b0;
    unique case (estado_q)
      BUSCA: begin
        mem_le = 1'b1;
        if (mem_pronto) begin
          ir_d       = mem_dado;
          pc_escreve = 1'b1;
          estado_d   = DECODIFICA;
        end else if (limite) begin
          estado_d = PARADO;
        end
      end
      DECODIFICA: begin
        if (op == OP_BEQ && ir_q[0]) estado_d = PARADO;
        else                         estado_d = EXECUTA;
      end
      EXECUTA: begin
        unique case (op)
          OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: begin
            sinal_ula = op;
            estado_d  = ESCRITA;
          end
          OP_LW, OP_SW: begin
            sinal_ula = OP_ADD;
            estado_d  = MEMORIA;
          end
          default: begin  // BEQ: ALU computes ra-rb, zero selects the skip
            sinal_ula  = OP_SUB;
            pc_escreve = zero;
            pc_fonte   = 1'b1;
            estado_d   = BUSCA;
          end
        endcase
      end
      MEMORIA: begin
        sel_endereco = 1'b1;
        if (op == OP_LW) begin
          mem_le      = 1'b1;
          sel_mem_reg = 1'b1;
        end else begin
          mem_escreve = 1'b1;
        end
        if (mem_pronto)  estado_d = (op == OP_LW) ? ESCRITA : BUSCA;
        else if (limite) estado_d = PARADO;
      end
      ESCRITA: begin
        reg_escreve = 1'b1;
        sel_mem_reg = (op == OP_LW);
        estado_d    = BUSCA;
      end
      PARADO: begin
        estado_d = PARADO;
      end
      default: begin
        estado_d = BUSCA;
      end
    endcase
  end

endmodule

// File: tb/tb_unidade_controle.sv
module tb_unidade_controle;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] mem_dado = 8'h00;
  logic       mem_pronto = 1'b0;
  logic       zero = 1'b0;
  logic [2:0] sinal_ula;
  logic [1:0] reg_a, reg_b;
  logic       mem_le, mem_escreve, sel_endereco, pc_escreve, pc_fonte;
  logic       reg_escreve, sel_mem_reg, parado, erro_timeout;

  unidade_controle dut (
    .clock(clock), .reset_n(reset_n), .mem_dado(mem_dado), .mem_pronto(mem_pronto),
    .zero(zero), .sinal_ula(sinal_ula), .reg_a(reg_a), .reg_b(reg_b),
    .mem_le(mem_le), .mem_escreve(mem_escreve), .sel_endereco(sel_endereco),
    .pc_escreve(pc_escreve), .pc_fonte(pc_fonte), .reg_escreve(reg_escreve),
    .sel_mem_reg(sel_mem_reg), .parado(parado), .erro_timeout(erro_timeout)
  );

  always #5 clock = ~clock;

  logic [15:0] exp_q[$];
  string       nm_q[$];
  int          n_total = 0;
  int          n_pass  = 0;

  // Expected output vector: ula, ra, rb, le, we, sel_end, pc_wr, pc_src, reg_wr, sel_mem, parado, erro
  function automatic logic [15:0] V(logic [2:0] u, logic [1:0] a, logic [1:0] b,
                                    logic le, logic we, logic se, logic pe, logic pf,
                                    logic re, logic smr, logic par, logic err);
    return {u, a, b, le, we, se, pe, pf, re, smr, par, err};
  endfunction

  task automatic step(input logic rn, input logic mp, input logic z, input logic [7:0] md,
                      input logic [15:0] e, input string nm);
    @(posedge clock);
    #1;
    reset_n    = rn;
    mem_pronto = mp;
    zero       = z;
    mem_dado   = md;
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  // Monitor: the FSM presents a full output vector every cycle; sample mid-cycle.
  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      logic [15:0] got, e;
      string n;
      got = {sinal_ula, reg_a, reg_b, mem_le, mem_escreve, sel_endereco, pc_escreve,
             pc_fonte, reg_escreve, sel_mem_reg, parado, erro_timeout};
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      n_total++;
      if (got !== e) $display("FAIL %s got=%b exp=%b (ula_ra_rb_le_we_se_pe_pf_re_smr_par_err)", n, got, e);
      else n_pass++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog pending=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  localparam logic [15:0] RST = 16'b000_00_00_1_0_0_0_0_0_0_0_0;

  initial begin
    // reset state
    step(0, 0, 0, 8'h00, RST, "reset0");
    step(0, 0, 0, 8'h00, RST, "reset1");

    // 1: ADD 010_01_10_0, no wait
    step(1, 1, 0, 8'h4C, V(0,0,0, 1,0,0,1,0,0,0,0,0), "t1_busca");
    step(1, 0, 1, 8'h00, V(0,1,2, 0,0,0,0,0,0,0,0,0), "t1_dec");
    step(1, 0, 1, 8'h00, V(2,1,2, 0,0,0,0,0,0,0,0,0), "t1_exe");
    step(1, 0, 0, 8'h00, V(0,1,2, 0,0,0,0,0,1,0,0,0), "t1_esc");

    // 2: OR 001_10_11_0 after 3 wait cycles in BUSCA
    for (int i = 0; i < 3; i++)
      step(1, 0, 0, 8'h36, V(0,1,2, 1,0,0,0,0,0,0,0,0), "t2_wait");
    step(1, 1, 0, 8'h36, V(0,1,2, 1,0,0,1,0,0,0,0,0), "t2_busca");
    step(1, 0, 0, 8'h00, V(0,2,3, 0,0,0,0,0,0,0,0,0), "t2_dec");
    step(1, 0, 0, 8'h00, V(1,2,3, 0,0,0,0,0,0,0,0,0), "t2_exe");
    step(1, 0, 0, 8'h00, V(0,2,3, 0,0,0,0,0,1,0,0,0), "t2_esc");

    // 3: LW 101_00_01_0 with 2 wait cycles in MEMORIA (7 cycles total)
    step(1, 1, 0, 8'hA2, V(0,2,3, 1,0,0,1,0,0,0,0,0), "t3_busca");
    step(1, 0, 0, 8'hFF, V(0,0,1, 0,0,0,0,0,0,0,0,0), "t3_dec");
    step(1, 0, 0, 8'hFF, V(2,0,1, 0,0,0,0,0,0,0,0,0), "t3_exe");
    step(1, 0, 0, 8'hFF, V(0,0,1, 1,0,1,0,0,0,1,0,0), "t3_memw0");
    step(1, 0, 0, 8'hFF, V(0,0,1, 1,0,1,0,0,0,1,0,0), "t3_memw1");
    step(1, 1, 0, 8'hFF, V(0,0,1, 1,0,1,0,0,0,1,0,0), "t3_mem");
    step(1, 0, 0, 8'hFF, V(0,0,1, 0,0,0,0,0,1,1,0,0), "t3_esc");

    // SW 110_01_10_0, no wait: 4 cycles
    step(1, 1, 0, 8'hCC, V(0,0,1, 1,0,0,1,0,0,0,0,0), "sw_busca");
    step(1, 0, 0, 8'h00, V(0,1,2, 0,0,0,0,0,0,0,0,0), "sw_dec");
    step(1, 0, 0, 8'h00, V(2,1,2, 0,0,0,0,0,0,0,0,0), "sw_exe");
    step(1, 1, 0, 8'h00, V(0,1,2, 0,1,1,0,0,0,0,0,0), "sw_mem");

    // 4: BEQ 8'hE4 with zero=1, then zero=0
    step(1, 1, 0, 8'hE4, V(0,1,2, 1,0,0,1,0,0,0,0,0), "t4_busca1");
    step(1, 0, 1, 8'h00, V(0,0,2, 0,0,0,0,0,0,0,0,0), "t4_dec1");
    step(1, 0, 1, 8'h00, V(3,0,2, 0,0,0,1,1,0,0,0,0), "t4_exe_z1");
    step(1, 1, 1, 8'hE4, V(0,0,2, 1,0,0,1,0,0,0,0,0), "t4_busca2");
    step(1, 0, 0, 8'h00, V(0,0,2, 0,0,0,0,0,0,0,0,0), "t4_dec2");
    step(1, 0, 0, 8'h00, V(3,0,2, 0,0,0,0,1,0,0,0,0), "t4_exe_z0");

    // ADD with IR[0]=1 is not a halt
    step(1, 1, 0, 8'h4D, V(0,0,2, 1,0,0,1,0,0,0,0,0), "b0_busca");
    step(1, 0, 0, 8'h00, V(0,1,2, 0,0,0,0,0,0,0,0,0), "b0_dec");
    step(1, 0, 0, 8'h00, V(2,1,2, 0,0,0,0,0,0,0,0,0), "b0_exe");
    step(1, 0, 0, 8'h00, V(0,1,2, 0,0,0,0,0,1,0,0,0), "b0_esc");

    // 5: HALT 8'hE1 -> PARADO after 2 cycles, ignores all inputs
    step(1, 1, 0, 8'hE1, V(0,1,2, 1,0,0,1,0,0,0,0,0), "t5_busca");
    step(1, 0, 0, 8'h00, V(0,0,0, 0,0,0,0,0,0,0,0,0), "t5_dec");
    for (int i = 0; i < 12; i++)
      step(1, 1, 1, 8'h4C, V(0,0,0, 0,0,0,0,0,0,0,1,0), "t5_parado");
    step(0, 0, 0, 8'h00, RST, "t5_reset");

    // reset pulse during EXECUTA of an SW: aborts, no mem_escreve
    step(1, 1, 0, 8'hCC, V(0,0,0, 1,0,0,1,0,0,0,0,0), "ab_busca");
    step(1, 0, 0, 8'h00, V(0,1,2, 0,0,0,0,0,0,0,0,0), "ab_dec");
    step(0, 0, 0, 8'h00, RST, "ab_reset");
    for (int i = 0; i < 3; i++)
      step(1, 0, 0, 8'h00, RST, "ab_after");

    // 6: memory never answers in BUSCA
    step(0, 0, 0, 8'h00, RST, "t6_reset");
`ifdef CONTROLE_TIMEOUT_EN
    for (int i = 0; i < 15; i++)
      step(1, 0, 0, 8'h00, RST, "t6_wait");
    for (int i = 0; i < 3; i++)
      step(1, 0, 0, 8'h00, V(0,0,0, 0,0,0,0,0,0,0,1,1), "t6_timeout");
`else
    for (int i = 0; i < 20; i++)
      step(1, 0, 0, 8'h00, RST, "t6_wait");
`endif

    repeat (3) @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
      n_total++;
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
